key_event_arbiter: RTL and testbench

//   Front end for the three active-low push-buttons (E, F, G) of the board top.

---
 rtl/key_event_arbiter.sv | 125 ++++++++++++
 tb/tb_key_event_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_arbiter.sv
// key_event_arbiter: synchronise and debounce three active-low keys, turn each
// debounced press into one event, and offer events round-robin on valid/ready.
`default_nettype none

module key_event_arbiter #(
  parameter int DB_CYCLES = 8,
  parameter int CNT_W     = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [2:0] key_n,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_code,
  output logic [2:0] held,
  output logic       overrun
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  state_t           state, state_next;
  logic [2:0]       sync1, sync2, stable, pending;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       flip, press, clr;
  logic [1:0]       last, winner, cand1, cand2;
  logic             take, done;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Any sample back at the stable level clears the run, so only an unbroken
  // run of DB_CYCLES differing samples moves the stable level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stable <= 3'b111;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) flip[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
  end

  assign press = flip & stable;
  assign held  = ~stable;

  // Round-robin scan order: last+1, last+2, last (mod 3).
  always_comb begin
    cand1  = (last == 2'd2) ? 2'd0 : last + 2'd1;
    cand2  = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
    winner = last;
    if (pending[cand1])      winner = cand1;
    else if (pending[cand2]) winner = cand2;
  end

  always_comb begin
    state_next = state;
    take       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (pending != 3'b000) begin
          take       = 1'b1;
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign clr = take ? (3'b001 << winner) : 3'b000;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      pending   <= 3'b000;
      last      <= 2'd2;
      evt_valid <= 1'b0;
      evt_code  <= 2'd0;
      overrun   <= 1'b0;
    end else begin
      state   <= state_next;
      // A press landing on the same edge as the grant re-arms the key.
      pending <= (pending & ~clr) | press;
      overrun <= |(press & pending & ~clr);
      if (take) begin
        evt_code  <= winner;
        evt_valid <= 1'b1;
      end
      if (done) begin
        evt_valid <= 1'b0;
        last      <= evt_code;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_key_event_arbiter.sv
// Bench for key_event_arbiter: directed scenarios with literal expectations plus
// randomized key/ready traffic checked every cycle against a behavioural model.
`default_nettype none

module tb_key_event_arbiter;

  localparam int DB = 8;
  localparam int HL = DB + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key_n = 3'b111;
  logic       evt_ready = 1'b1;
  logic       evt_valid, overrun;
  logic [1:0] evt_code;
  logic [2:0] held;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  key_event_arbiter #(.DB_CYCLES(DB), .CNT_W(4)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .key_n(key_n),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .held(held), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: history of raw samples per key; a level flips when the
  // DB samples seen by the debouncer (2..DB+1 edges old) all differ from it.
  logic [HL-1:0] m_hist [3];
  logic [2:0]    m_stable, m_pending;
  logic          m_offer, m_overrun;
  logic [1:0]    m_code, m_last;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 3; i++) m_hist[i] = '1;
        m_stable = 3'b111; m_pending = 3'b000; m_offer = 0;
        m_overrun = 0; m_code = 2'd0; m_last = 2'd2;
      end else begin
        logic [2:0] flips, presses, grant;
        int w;
        flips = 3'b000;
        for (int i = 0; i < 3; i++) begin
          m_hist[i] = {m_hist[i][HL-2:0], key_n[i]};
          if (m_hist[i][HL-1:2] == {DB{~m_stable[i]}}) flips[i] = 1'b1;
        end
        presses  = flips & m_stable;
        m_stable = m_stable ^ flips;
        grant = 3'b000;
        if (!m_offer && m_pending != 0) begin
          w = -1;
          for (int k = 1; k <= 3 && w < 0; k++)
            if (m_pending[(m_last + k) % 3]) w = (m_last + k) % 3;
          grant[w] = 1'b1;
          m_code   = 2'(w);
          m_offer  = 1;
        end else if (m_offer && evt_ready) begin
          m_offer = 0;
          m_last  = m_code;
        end
        m_overrun = |(presses & m_pending & ~grant);
        m_pending = (m_pending & ~grant) | presses;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("valid", {31'd0, evt_valid}, {31'd0, m_offer});
        chk("code", {30'd0, evt_code}, {30'd0, m_code});
        chk("held", {29'd0, held}, {29'd0, ~m_stable});
        chk("overrun", {31'd0, overrun}, {31'd0, m_overrun});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic idle_count(input int n, output int vcnt, output int ocnt);
    vcnt = 0; ocnt = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      vcnt += int'(evt_valid);
      ocnt += int'(overrun);
    end
  endtask

  initial begin
    int vc, oc, first, hs;
    int t_ev [6];
    int c_ev [6];

    tick(); tick();
    chk("rst_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_held", {29'd0, held}, 32'd0);
    chk("rst_code", {30'd0, evt_code}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    chk_en = 1;
    tick();

    // Clean press of G
    key_n = 3'b110; vc = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      vc += int'(evt_valid);
      if (k == 9)  chk("t1_held9", {29'd0, held}, 32'd0);
      if (k == 10) chk("t1_held10", {29'd0, held}, 32'd1);
      if (k == 10) chk("t1_valid10", {31'd0, evt_valid}, 32'd0);
      if (k == 11) chk("t1_valid11", {31'd0, evt_valid}, 32'd1);
      if (k == 11) chk("t1_code11", {30'd0, evt_code}, 32'd0);
      if (k == 12) chk("t1_valid12", {31'd0, evt_valid}, 32'd0);
    end
    chk("t1_events", vc, 1);
    key_n = 3'b111;
    idle_count(30, vc, oc);
    chk("t1_release_events", vc, 0);

    // Bounce then release
    vc = 0; oc = 0;
    for (int p = 0; p < 5; p++) begin
      key_n[0] = 1'b0; tick(); vc += int'(evt_valid); oc += int'(overrun);
      key_n[0] = 1'b1; tick(); vc += int'(evt_valid); oc += int'(overrun);
      chk("t2_held", {29'd0, held}, 32'd0);
    end
    idle_count(20, first, hs);
    chk("t2_events", vc + first, 0);
    chk("t2_overrun", oc + hs, 0);

    // Bounce then hold low
    for (int p = 0; p < 5; p++) begin
      key_n[0] = 1'b0; tick();
      key_n[0] = 1'b1; tick();
    end
    key_n[0] = 1'b0; first = -1; vc = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (evt_valid && first < 0) first = k;
      if (evt_valid) chk("t3_code", {30'd0, evt_code}, 32'd0);
      vc += int'(evt_valid);
    end
    chk("t3_first_edge", first, DB + 3);
    chk("t3_events", vc, 1);
    key_n = 3'b111;
    idle_count(30, vc, oc);

    // All three keys together, twice
    do_reset();
    for (int r = 0; r < 2; r++) begin
      key_n = 3'b000; hs = 0;
      for (int k = 1; k <= 25; k++) begin
        tick();
        if (evt_valid && hs < 3) begin
          t_ev[r*3+hs] = k; c_ev[r*3+hs] = int'(evt_code); hs++;
        end
      end
      chk("t4_count", hs, 3);
      for (int j = 0; j < 3; j++) begin
        chk("t4_code", c_ev[r*3+j], j);
        chk("t4_edge", t_ev[r*3+j], DB + 3 + 2*j);
      end
      key_n = 3'b111;
      idle_count(30, vc, oc);
    end

    // Stalled consumer with repeated F presses
    evt_ready = 1'b0; oc = 0;
    for (int r = 0; r < 3; r++) begin
      key_n = 3'b101;
      for (int k = 0; k < 14; k++) begin tick(); oc += int'(overrun); end
      key_n = 3'b111;
      for (int k = 0; k < 14; k++) begin tick(); oc += int'(overrun); end
    end
    chk("t5_valid_stalled", {31'd0, evt_valid}, 32'd1);
    chk("t5_code_stalled", {30'd0, evt_code}, 32'd1);
    chk("t5_overrun", oc, 1);
    evt_ready = 1'b1; hs = 0;
    for (int k = 0; k < 20; k++) begin
      if (evt_valid) begin
        hs++;
        chk("t5_code", {30'd0, evt_code}, 32'd1);
      end
      tick();
    end
    chk("t5_handshakes", hs, 2);

    // Reset during OFFER
    evt_ready = 1'b0; key_n = 3'b011;
    for (int k = 0; k < 14; k++) tick();
    chk("t6_valid_before", {31'd0, evt_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid_reset", {31'd0, evt_valid}, 32'd0);
    chk("t6_held_reset", {29'd0, held}, 32'd0);
    key_n = 3'b111;
    tick(); tick();
    rst_n = 1'b1; evt_ready = 1'b1;
    idle_count(30, vc, oc);
    chk("t6_no_event", vc, 0);

    // Randomized traffic: bouncy phase then slow phase
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, (k < 1500) ? 3 : 20) == 0) key_n[i] = ~key_n[i];
      evt_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0; tick(); rst_n = 1'b1;
      end
      tick();
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
